uart_tx_queue: RTL and testbench



---
 rtl/uart_tx_queue.sv | 117 +++++++++++
 tb/tb_uart_tx_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Transmit queue in front of a toggle-mode UART driver.
// A power-of-two FIFO feeds a four-state sequencer that pops one word,
// presents it on tx_reg, toggles send, then waits for busy to rise and fall.
// Overflow and lost-handshake (arm timeout) are captured in sticky flags.
module uart_tx_queue #(
  parameter int BIT_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ARM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BIT_WIDTH-1:0]  wr_data,
  input  logic                  enable,
  input  logic                  clr_flags,
  input  logic                  busy,
  output logic                  send,
  output logic [BIT_WIDTH-1:0]  tx_reg,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  active,
  output logic                  overflow,
  output logic                  timeout
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [7:0]        ARM_LIM  = 8'(ARM_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, ARM, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [BIT_WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [7:0]              arm_cnt;
  logic                    push, pop, arm_expire;

  // full/empty come straight from the registered count, so no pop bypass
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign active = (state != IDLE);

  assign push       = wr_en && !full;
  assign pop        = (state == IDLE) && enable && !empty && !busy;
  assign arm_expire = (state == ARM) && !busy && ((arm_cnt + 8'd1) == ARM_LIM);

  // FIFO storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // pointers and occupancy; pointers wrap naturally at 2^ADDR_WIDTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // sequencer next-state: busy rising wins over the arm timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LOAD;
      LOAD:    state_nxt = ARM;
      ARM:     if (busy) state_nxt = DRAIN;
               else if (arm_expire) state_nxt = IDLE;
      DRAIN:   if (!busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // word latch, send toggle and arm-wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_reg  <= '0;
      send    <= 1'b0;
      arm_cnt <= '0;
    end else begin
      if (pop) tx_reg <= mem[rd_ptr];
      if (state == LOAD) begin
        send    <= ~send;
        arm_cnt <= '0;
      end else if (state == ARM && !busy) begin
        arm_cnt <= arm_cnt + 8'd1;
      end
    end
  end

  // sticky flags; a set in the same cycle as clr_flags takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      overflow <= (overflow && !clr_flags) || (wr_en && full);
      timeout  <= (timeout  && !clr_flags) || arm_expire;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against a queue-based transaction model.
module tb_uart_tx_queue;

  localparam int BW = 8, AW = 4, TO = 15, DEPTH = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          wr_en = 1'b0, enable = 1'b0, clr_flags = 1'b0, busy = 1'b0;
  logic [BW-1:0] wr_data = '0;
  logic          send, full, empty, active, overflow, timeout;
  logic [BW-1:0] tx_reg;
  logic [AW:0]   count;

  uart_tx_queue #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .ARM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .enable(enable),
    .clr_flags(clr_flags), .busy(busy), .send(send), .tx_reg(tx_reg),
    .full(full), .empty(empty), .count(count), .active(active),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // queue of pending words, plus the one word in flight described by its
  // age (edges since pop) and whether busy has been observed yet
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_tx = '0;
  logic          m_send = 0, m_fly = 0, m_seen = 0, m_ovf = 0, m_to = 0;
  int            m_age = 0;

  initial begin
    int n0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete(); m_tx = '0; m_send = 0; m_fly = 0; m_seen = 0;
        m_ovf = 0; m_to = 0; m_age = 0;
      end else begin
        n0 = mq.size();
        if (clr_flags) begin m_ovf = 0; m_to = 0; end
        if (wr_en && n0 == DEPTH) m_ovf = 1;
        if (!m_fly) begin
          if (enable && n0 > 0 && !busy) begin
            m_tx = mq.pop_front(); m_fly = 1; m_age = 0; m_seen = 0;
          end
        end else if (m_age == 0) begin
          m_send = ~m_send; m_age = 1;
        end else begin
          m_age++;
          if (m_seen) begin
            if (!busy) m_fly = 0;
          end else if (busy) m_seen = 1;
          else if (m_age == TO + 1) begin m_to = 1; m_fly = 0; end
        end
        if (wr_en && n0 < DEPTH) mq.push_back(wr_data);
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("send",     32'(send),     32'(m_send));
      chk("tx_reg",   32'(tx_reg),   32'(m_tx));
      chk("count",    32'(count),    32'(mq.size()));
      chk("empty",    32'(empty),    32'(mq.size() == 0));
      chk("full",     32'(full),     32'(mq.size() == DEPTH));
      chk("active",   32'(active),   32'(m_fly));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("timeout",  32'(timeout),  32'(m_to));
    end
  end

  // ---------------- toggle observer ----------------
  logic          prev_send = 0;
  int            tog_cnt = 0;
  logic [BW-1:0] tog_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst && send !== prev_send) begin tog_cnt++; tog_q.push_back(tx_reg); end
      prev_send = send;
    end
  end

  // ---------------- behavioural driver ----------------
  logic drv_en = 0, hist = 0;
  int   drv_dly_max = 0, frm_max = 6;
  initial begin
    int d, f;
    forever begin
      @(posedge clk); #1;
      if (drv_en && rst && send !== hist) begin
        hist = send;
        d = (drv_dly_max == 0) ? 0 : $urandom_range(0, drv_dly_max);
        repeat (d) begin @(posedge clk); #1; end
        busy = 1;
        f = $urandom_range(1, frm_max);
        repeat (f) begin @(posedge clk); #1; end
        busy = 0;
      end else if (!drv_en) hist = send;
    end
  end

  // ---------------- helpers ----------------
  task automatic push(input logic [BW-1:0] w);
    wr_en = 1; wr_data = w;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    clr_flags = 1; step(); clr_flags = 0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (!(empty && !active && !busy) && k < lim) begin step(); k++; end
    if (k >= lim) chk("wait_idle bound", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [BW-1:0] w17[17];
  logic          sv;
  initial begin
    #1 rst = 0;
    #1;
    chk("rst send", 32'(send), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst count", 32'(count), 0);
    chk("rst active", 32'(active), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    enable = 1;
    step();

    // single word
    push(8'hA5);
    chk("t1 count", 32'(count), 1);
    chk("t1 empty", 32'(empty), 0);
    step();
    chk("t1 tx_reg", 32'(tx_reg), 32'hA5);
    chk("t1 active", 32'(active), 1);
    step();
    chk("t1 send", 32'(send), 1);
    busy = 1;
    for (int i = 0; i < 20; i++) begin step(); chk("t1 hold count", 32'(count), 0); end
    busy = 0;
    step();
    chk("t1 active fall", 32'(active), 0);

    // burst
    drv_en = 1; drv_dly_max = 0; frm_max = 6;
    tog_cnt = 0; tog_q.delete();
    push(8'h01); push(8'h02); push(8'h03);
    wait_idle(500);
    chk("t2 toggles", 32'(tog_cnt), 3);
    chk("t2 send", 32'(send), 0);
    for (int i = 0; i < 3 && i < tog_q.size(); i++) chk("t2 order", 32'(tog_q[i]), 32'(i + 1));

    // full and overflow
    enable = 0;
    for (int i = 0; i < 17; i++) begin w17[i] = 8'($urandom); push(w17[i]); end
    chk("t3 full", 32'(full), 1);
    chk("t3 count", 32'(count), 16);
    chk("t3 overflow", 32'(overflow), 1);
    tog_cnt = 0; tog_q.delete();
    enable = 1;
    wait_idle(3000);
    chk("t3 drained", 32'(tog_cnt), 16);
    for (int i = 0; i < 16 && i < tog_q.size(); i++) chk("t3 order", 32'(tog_q[i]), 32'(w17[i]));
    pulse_clr();
    chk("t3 clr", 32'(overflow), 0);

    // timeout
    drv_en = 0; step();
    sv = send;
    push(8'h3C);
    step();
    chk("t4 tx_reg", 32'(tx_reg), 32'h3C);
    step();
    chk("t4 toggle", 32'(send), 32'(!sv));
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("t4 early timeout", 32'(timeout), 0);
      chk("t4 still armed", 32'(active), 1);
    end
    step();
    chk("t4 timeout", 32'(timeout), 1);
    chk("t4 idle", 32'(active), 0);
    pulse_clr();
    chk("t4 clr", 32'(timeout), 0);

    // async reset mid-DRAIN (a throwaway timed-out word first puts send at 0)
    push(8'h55);
    repeat (20) step();
    pulse_clr();
    push(8'h77);
    step(); step();
    chk("t5 toggle", 32'(send), 1);
    busy = 1;
    push(8'h11); push(8'h22); push(8'h33);
    chk("t5 queued", 32'(count), 3);
    @(posedge clk); #3 rst = 0;
    #1;
    chk("t5 send", 32'(send), 0);
    chk("t5 tx_reg", 32'(tx_reg), 0);
    chk("t5 count", 32'(count), 0);
    chk("t5 empty", 32'(empty), 1);
    chk("t5 active", 32'(active), 0);
    chk("t5 flags", 32'({overflow, timeout}), 0);
    @(negedge clk); busy = 0; rst = 1;
    repeat (10) step();
    chk("t5 no toggle", 32'(send), 0);
    push(8'h99);
    step(); step();
    chk("t5 new toggle", 32'(send), 1);
    chk("t5 new word", 32'(tx_reg), 32'h99);
    repeat (TO + 2) step();
    pulse_clr();

    // randomized traffic, including late busy that forces timeouts
    drv_en = 1; drv_dly_max = 18; frm_max = 8;
    for (int i = 0; i < 3000; i++) begin
      wr_en     = ($urandom_range(0, 99) < 40);
      wr_data   = 8'($urandom);
      enable    = ($urandom_range(0, 99) < 90);
      clr_flags = ($urandom_range(0, 99) < 3);
      step();
    end
    wr_en = 0; clr_flags = 0; enable = 1;
    wait_idle(5000);
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
